// File: rtl/vga_pkg.sv
// Shared VGA timing constants, widths and sync bundle for the
// timing generator and all draw layers.
package vga_pkg;

    localparam int H_VISIBLE = 800;
    localparam int H_FP      = 56;
    localparam int H_SYNC    = 120;
    localparam int H_BP      = 64;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int V_VISIBLE = 600;
    localparam int V_FP      = 37;
    localparam int V_SYNC    = 6;
    localparam int V_BP      = 23;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int X_W  = 11;
    localparam int Y_W  = 10;
    localparam int FC_W = 8;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank;
        logic frame_start;
    } vga_sync_t;

    function automatic vga_sync_t sync_idle(input logic pol);
        vga_sync_t s;
        s.hsync       = ~pol;
        s.vsync       = ~pol;
        s.blank       = 1'b1;
        s.frame_start = 1'b0;
        return s;
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster position and sync bundle produced by vga_timing and
// consumed by the draw layers and the connector.
interface vga_timing_if;
    import vga_pkg::*;

    logic [X_W-1:0]  x;
    logic [Y_W-1:0]  y;
    logic            hsync;
    logic            vsync;
    logic            blank;
    logic            frame_start;
    logic [FC_W-1:0] frame_cnt;

    modport master (
        output x, y, hsync, vsync, blank, frame_start, frame_cnt
    );

    modport slave (
        input x, y, hsync, vsync, blank, frame_start, frame_cnt
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus sync/visible decode of the
// value it will hold after the coming edge.
module vga_axis_counter #(
    parameter int VISIBLE = 800,
    parameter int FP      = 56,
    parameter int SYNC    = 120,
    parameter int BP      = 64,
    parameter int W       = 11
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_wrap,
    output logic         o_sync_nxt,
    output logic         o_vis_nxt
);

    localparam int TOTAL = VISIBLE + FP + SYNC + BP;
    localparam logic [W-1:0] L_LAST     = W'(TOTAL - 1);
    localparam logic [W-1:0] L_SYNC_ON  = W'(VISIBLE + FP);
    localparam logic [W-1:0] L_SYNC_OFF = W'(VISIBLE + FP + SYNC);
    localparam logic [W-1:0] L_VIS      = W'(VISIBLE);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_nxt;
    logic         w_last;

    assign w_last = (r_cnt == L_LAST);
    assign o_wrap = i_en & w_last;

    always_comb begin
        w_nxt = r_cnt;
        if (i_en) begin
            w_nxt = w_last ? '0 : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_nxt;
        end
    end

    // Decoding the next value lets registered flags line up with o_cnt.
    assign o_cnt      = r_cnt;
    assign o_sync_nxt = (w_nxt >= L_SYNC_ON) && (w_nxt < L_SYNC_OFF);
    assign o_vis_nxt  = (w_nxt < L_VIS);

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator. Define VGA_SYNC_ALIGN_EN to delay
// hsync/vsync/blank/frame_start one cycle behind x/y.
module vga_timing #(
    parameter int   H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int   H_FP      = vga_pkg::H_FP,
    parameter int   H_SYNC    = vga_pkg::H_SYNC,
    parameter int   H_BP      = vga_pkg::H_BP,
    parameter int   V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int   V_FP      = vga_pkg::V_FP,
    parameter int   V_SYNC    = vga_pkg::V_SYNC,
    parameter int   V_BP      = vga_pkg::V_BP,
    parameter logic SYNC_POL  = 1'b1
) (
    input  logic          vga_clk,
    input  logic          rst,
    vga_timing_if.master  vif
);
    import vga_pkg::*;

    logic [X_W-1:0]  w_x;
    logic [Y_W-1:0]  w_y;
    logic            w_h_wrap;
    logic            w_v_wrap;
    logic            w_h_sync;
    logic            w_v_sync;
    logic            w_h_vis;
    logic            w_v_vis;
    vga_sync_t       w_sync_nxt;
    vga_sync_t       r_sync;
    vga_sync_t       w_sync_out;
    logic [FC_W-1:0] r_frame_cnt;

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FP      (H_FP),
        .SYNC    (H_SYNC),
        .BP      (H_BP),
        .W       (X_W)
    ) u_h_axis (
        .i_clk      (vga_clk),
        .i_rst      (rst),
        .i_en       (1'b1),
        .o_cnt      (w_x),
        .o_wrap     (w_h_wrap),
        .o_sync_nxt (w_h_sync),
        .o_vis_nxt  (w_h_vis)
    );

    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FP      (V_FP),
        .SYNC    (V_SYNC),
        .BP      (V_BP),
        .W       (Y_W)
    ) u_v_axis (
        .i_clk      (vga_clk),
        .i_rst      (rst),
        .i_en       (w_h_wrap),
        .o_cnt      (w_y),
        .o_wrap     (w_v_wrap),
        .o_sync_nxt (w_v_sync),
        .o_vis_nxt  (w_v_vis)
    );

    always_comb begin
        w_sync_nxt.hsync       = w_h_sync ? SYNC_POL : ~SYNC_POL;
        w_sync_nxt.vsync       = w_v_sync ? SYNC_POL : ~SYNC_POL;
        w_sync_nxt.blank       = ~(w_h_vis & w_v_vis);
        // Only a wrap reaches (0,0) here, never the reset-held origin.
        w_sync_nxt.frame_start = w_v_wrap;
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            r_sync      <= sync_idle(SYNC_POL);
            r_frame_cnt <= '0;
        end else begin
            r_sync <= w_sync_nxt;
            if (w_v_wrap) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

`ifdef VGA_SYNC_ALIGN_EN
    vga_sync_t r_sync_d;

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            r_sync_d <= sync_idle(SYNC_POL);
        end else begin
            r_sync_d <= r_sync;
        end
    end

    assign w_sync_out = r_sync_d;
`else
    assign w_sync_out = r_sync;
`endif

    assign vif.x           = w_x;
    assign vif.y           = w_y;
    assign vif.hsync       = w_sync_out.hsync;
    assign vif.vsync       = w_sync_out.vsync;
    assign vif.blank       = w_sync_out.blank;
    assign vif.frame_start = w_sync_out.frame_start;
    assign vif.frame_cnt   = r_frame_cnt;

endmodule
